// File: rtl/nand_data_flow_pkg.sv
// rtl/nand_data_flow_pkg.sv - shared defaults and helpers for the NAND cell
package nand_data_flow_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    // Largest value a w-bit unsigned counter can hold (clamped to 32 bits).
    function automatic logic [31:0] sat_max(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/nand_data_flow_sat_counter.sv
// rtl/nand_data_flow_sat_counter.sv - saturating event counter with sync clear
module sat_counter
    import nand_data_flow_pkg::*;
#(
    parameter int W = DEFAULT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = W'(sat_max(W));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/nand_data_flow.sv
// rtl/nand_data_flow.sv - bitwise NAND cell with registered copy and activity counters
module nand_data_flow
    import nand_data_flow_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [WIDTH-1:0] Y_q,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic low_inc;
    logic toggle_inc;

    // Purely combinational so truth-table benches work with the clock stopped.
    assign Y = ~(A & B);

    assign low_inc    = (Y != {WIDTH{1'b1}});
    assign toggle_inc = (Y != Y_q);

    // Reset value is the NAND of 0,0 so an idle cell reports no toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q <= {WIDTH{1'b1}};
        end else begin
            Y_q <= Y;
        end
    end

    sat_counter #(.W(CNT_W)) u_low_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (low_inc),
        .count (low_cnt)
    );

    sat_counter #(.W(CNT_W)) u_toggle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (toggle_inc),
        .count (toggle_cnt)
    );

endmodule

// File: tb/tb_nand_data_flow.sv
// tb/tb_nand_data_flow.sv - randomized self-checking bench for nand_data_flow
module tb_nand_data_flow;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst = 1'b1;
    logic       clr = 1'b0;

    logic [0:0] a1, b1, y1, yq1;
    logic [2:0] low1, tog1;
    logic [3:0] a4, b4, y4, yq4;
    logic [4:0] low4, tog4;

    int n_checks = 0;
    int n_fail = 0;

    int m_yq[2];
    int m_low[2];
    int m_tog[2];
    int ones[2] = '{1, 15};
    int maxv[2] = '{7, 31};

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    nand_data_flow #(.WIDTH(1), .CNT_W(3)) u_dut1 (
        .Y(y1), .A(a1), .B(b1), .clk(clk), .rst(rst), .clr(clr),
        .Y_q(yq1), .low_cnt(low1), .toggle_cnt(tog1)
    );

    nand_data_flow #(.WIDTH(4), .CNT_W(5)) u_dut4 (
        .Y(y4), .A(a4), .B(b4), .clk(clk), .rst(rst), .clr(clr),
        .Y_q(yq4), .low_cnt(low4), .toggle_cnt(tog4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int i, input int a, input int b);
        int y;
        y = ~(a & b) & ones[i];
        if (rst) begin
            m_yq[i] = ones[i];
            m_low[i] = 0;
            m_tog[i] = 0;
        end else if (clr) begin
            m_yq[i] = y;
            m_low[i] = 0;
            m_tog[i] = 0;
        end else begin
            if (y != ones[i] && m_low[i] < maxv[i]) m_low[i]++;
            if (y != m_yq[i] && m_tog[i] < maxv[i]) m_tog[i]++;
            m_yq[i] = y;
        end
    endtask

    task automatic check_all();
        check("y1",    32'(y1),   32'(~(int'(a1) & int'(b1)) & 1));
        check("yq1",   32'(yq1),  32'(m_yq[0]));
        check("low1",  32'(low1), 32'(m_low[0]));
        check("tog1",  32'(tog1), 32'(m_tog[0]));
        check("y4",    32'(y4),   32'(~(int'(a4) & int'(b4)) & 15));
        check("yq4",   32'(yq4),  32'(m_yq[1]));
        check("low4",  32'(low4), 32'(m_low[1]));
        check("tog4",  32'(tog4), 32'(m_tog[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(0, int'(a1), int'(b1));
        model_edge(1, int'(a4), int'(b4));
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] tt;
        tt = 4'b0111;
        a1 = 1'b1; b1 = 1'b1; a4 = 4'h0; b4 = 4'h0;
        rst = 1'b1; clr = 1'b0;

        repeat (2) begin
            cycle();
            check("rst_y", 32'(y1), 32'd0);
        end
        rst = 1'b0;
        check("rst_yq", 32'(yq1), 32'd1);
        check("rst_low", 32'(low1), 32'd0);
        check("rst_tog", 32'(tog1), 32'd0);

        repeat (5) cycle();
        a1 = 1'b0;
        repeat (3) cycle();
        check("cnt_low", 32'(low1), 32'd5);
        check("cnt_tog", 32'(tog1), 32'd2);

        a1 = 1'b1; rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (10) cycle();
        check("sat_low", 32'(low1), 32'd7);
        check("sat_tog", 32'(tog1), 32'd1);

        clr = 1'b1;
        cycle();
        check("clr_low", 32'(low1), 32'd0);
        check("clr_yq", 32'(yq1), 32'd0);
        rst = 1'b1;
        cycle();
        check("clr_rst_yq", 32'(yq1), 32'd1);
        clr = 1'b0; rst = 1'b0;

        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        check("w4_y", 32'(y4), 32'h7);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            check("w4_low_inc", 32'(low4), 32'(k));
        end

        clk_en = 1'b0;
        #10;
        for (int i = 0; i < 4; i++) begin
            a1 = 1'((i >> 1) & 1);
            b1 = 1'(i & 1);
            #1;
            check("tt_y", 32'(y1), 32'(tt[i]));
            check("tt_yq_hold", 32'(yq1), 32'(m_yq[0]));
            check("tt_low_hold", 32'(low1), 32'(m_low[0]));
            check("tt_tog_hold", 32'(tog1), 32'(m_tog[0]));
        end
        clk_en = 1'b1;

        repeat (400) begin
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 127) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
